half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 20 ++
 rtl/half_adder_bit.sv | 12 +
 rtl/half_adder.sv | 92 +++++++++
 tb/tb_half_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the lane-parallel half adder.
package half_adder_pkg;

   localparam int HA_WIDTH_DEFAULT = 1;
   localparam int HA_WIDTH_MAX     = 64;

   function automatic int ha_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic logic [6:0] ha_popcount(input logic [HA_WIDTH_MAX-1:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < HA_WIDTH_MAX; i++) begin
         n = n + {6'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single combinational half-adder lane.
module half_adder_bit (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);

   assign s  = a ^ b;
   assign co = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with carry summary, one cycle latency.
// Optional parity output enabled by HALF_ADDER_PARITY_EN.
module half_adder
   import half_adder_pkg::*;
#(
   parameter  int WIDTH = HA_WIDTH_DEFAULT,
   localparam int CNT_W = ha_cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Co,
   output logic             co_any,
   output logic [CNT_W-1:0] co_count
`ifdef HALF_ADDER_PARITY_EN
   ,
   output logic             parity
`endif
);

   logic [WIDTH-1:0] s_w;
   logic [WIDTH-1:0] co_w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .a  (A[i]),
         .b  (B[i]),
         .s  (s_w[i]),
         .co (co_w[i])
      );
   end

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] co_q, co_d;
   logic             co_any_q, co_any_d;
   logic [CNT_W-1:0] co_count_q, co_count_d;
   logic             parity_q, parity_d;

   // Data registers only load on a valid input, so X on idle operands never reaches them.
   always_comb begin
      out_valid_d = in_valid;
      s_d         = s_q;
      co_d        = co_q;
      co_any_d    = co_any_q;
      co_count_d  = co_count_q;
      parity_d    = parity_q;
      if (in_valid) begin
         s_d        = s_w;
         co_d       = co_w;
         co_any_d   = |co_w;
         co_count_d = CNT_W'(ha_popcount(HA_WIDTH_MAX'(co_w)));
         parity_d   = ^s_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         co_q        <= '0;
         co_any_q    <= 1'b0;
         co_count_q  <= '0;
         parity_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         co_q        <= co_d;
         co_any_q    <= co_any_d;
         co_count_q  <= co_count_d;
         parity_q    <= parity_d;
      end
   end

   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign Co        = co_q;
   assign co_any    = co_any_q;
   assign co_count  = co_count_q;

`ifdef HALF_ADDER_PARITY_EN
   assign parity = parity_q;
`else
   logic unused_parity;
   assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder at WIDTH = 1, 4 and 8 driven in lockstep.
module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv;
   logic [7:0] a, b;

   always #5 clk = ~clk;

   logic       o1_v, o1_any;
   logic [0:0] o1_s, o1_co, o1_cnt;
   logic       o4_v, o4_any;
   logic [3:0] o4_s, o4_co;
   logic [2:0] o4_cnt;
   logic       o8_v, o8_any;
   logic [7:0] o8_s, o8_co;
   logic [3:0] o8_cnt;
   logic       o1_par, o4_par, o8_par;

   half_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(iv), .A(a[0:0]), .B(b[0:0]),
      .out_valid(o1_v), .S(o1_s), .Co(o1_co), .co_any(o1_any), .co_count(o1_cnt)
`ifdef HALF_ADDER_PARITY_EN
      , .parity(o1_par)
`endif
   );

   half_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(iv), .A(a[3:0]), .B(b[3:0]),
      .out_valid(o4_v), .S(o4_s), .Co(o4_co), .co_any(o4_any), .co_count(o4_cnt)
`ifdef HALF_ADDER_PARITY_EN
      , .parity(o4_par)
`endif
   );

   half_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(iv), .A(a), .B(b),
      .out_valid(o8_v), .S(o8_s), .Co(o8_co), .co_any(o8_any), .co_count(o8_cnt)
`ifdef HALF_ADDER_PARITY_EN
      , .parity(o8_par)
`endif
   );

   typedef struct packed {
      logic       ov;
      logic [7:0] s;
      logic [7:0] co;
      logic       any;
      logic [3:0] cnt;
      logic       par;
   } exp_t;

   typedef struct packed {
      exp_t e1;
      exp_t e4;
      exp_t e8;
   } trip_t;

   trip_t sbq[$];
   exp_t  m1 = '0, m4 = '0, m8 = '0;
   int    n_cmp = 0;
   int    n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mdl(input exp_t cur, input int w, input logic r, input logic v,
                                input logic [7:0] av, input logic [7:0] bv);
      exp_t       n;
      logic [7:0] m;
      n = cur;
      m = 8'((1 << w) - 1);
      if (r) begin
         n = '0;
      end else if (v) begin
         n.ov  = 1'b1;
         n.s   = (av ^ bv) & m;
         n.co  = (av & bv) & m;
         n.any = |n.co;
         n.cnt = 4'($countones(n.co));
         n.par = ^n.s;
      end else begin
         n.ov = 1'b0;
      end
      return n;
   endfunction

   task automatic cmp(input string nm, input exp_t e, input logic ov, input logic [7:0] s,
                      input logic [7:0] co, input logic any, input logic [3:0] cnt,
                      input logic par);
      chk({nm, ".out_valid"}, {31'd0, ov}, {31'd0, e.ov});
      chk({nm, ".S"}, {24'd0, s}, {24'd0, e.s});
      chk({nm, ".Co"}, {24'd0, co}, {24'd0, e.co});
      chk({nm, ".co_any"}, {31'd0, any}, {31'd0, e.any});
      chk({nm, ".co_count"}, {28'd0, cnt}, {28'd0, e.cnt});
`ifdef HALF_ADDER_PARITY_EN
      chk({nm, ".parity"}, {31'd0, par}, {31'd0, e.par});
`else
      if (par === 1'bz && e.par === 1'bz) n_cmp = n_cmp + 0;
`endif
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv);
      trip_t t;
      rst = r;
      iv  = v;
      a   = av;
      b   = bv;
      m1 = mdl(m1, 1, r, v, av, bv);
      m4 = mdl(m4, 4, r, v, av, bv);
      m8 = mdl(m8, 8, r, v, av, bv);
      t.e1 = m1;
      t.e4 = m4;
      t.e8 = m8;
      sbq.push_back(t);
      @(posedge clk);
      #1;
      t = sbq.pop_front();
      cmp("w1", t.e1, o1_v, {7'd0, o1_s}, {7'd0, o1_co}, o1_any, {3'd0, o1_cnt}, o1_par);
      cmp("w4", t.e4, o4_v, {4'd0, o4_s}, {4'd0, o4_co}, o4_any, {1'd0, o4_cnt}, o4_par);
      cmp("w8", t.e8, o8_v, o8_s, o8_co, o8_any, o8_cnt, o8_par);
   endtask

   initial begin
      rst = 1'b1;
      iv  = 1'b0;
      a   = '0;
      b   = '0;
      #1;
      // Reset with a valid all-ones input: everything must come out zero.
      step(1'b1, 1'b1, 8'hFF, 8'hFF);
      step(1'b1, 1'b1, 8'hFF, 8'hFF);
      // Single-lane truth table, back to back.
      step(1'b0, 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b1, 8'h00, 8'h01);
      step(1'b0, 1'b1, 8'h01, 8'h00);
      step(1'b0, 1'b1, 8'h01, 8'h01);
      step(1'b0, 1'b1, 8'b0000_1011, 8'b0000_0110);
      step(1'b0, 1'b1, 8'h0F, 8'h0F);
      // Idle with unknown operands: outputs hold, no X.
      step(1'b0, 1'b0, 8'hxx, 8'hxx);
      step(1'b0, 1'b0, 8'hxx, 8'hxx);
      // Mid-stream reset dropping a valid, then first result after it.
      step(1'b1, 1'b1, 8'h0F, 8'h0F);
      step(1'b0, 1'b1, 8'h5A, 8'h3C);
      step(1'b0, 1'b1, 8'h01, 8'h00);
      step(1'b0, 1'b1, 8'h03, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b1, 8'hFF, 8'hFF);
      for (int i = 0; i < 1000; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
